// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg
// Shared constants for the exception-status writeback controller:
//   - status codes written to rstatus for each exception source
//   - default rstatus register index and pending-buffer depth
//   - occupancy encodings of the pending-status buffer
//   - helpers that validate and encode the ALU exception code
// ---------------------------------------------------------------------------
package exc_pkg;

    typedef logic [31:0] status_t;

    localparam status_t EXC_ADD  = 32'd1;
    localparam status_t EXC_ADDI = 32'd2;
    localparam status_t EXC_SUB  = 32'd3;
    localparam status_t EXC_MUL  = 32'd4;
    localparam status_t EXC_DIV  = 32'd5;

    localparam int RS_ADDR_DEF = 30;
    localparam int DEPTH_DEF   = 2;

    // Occupancy encodings double as the entry count.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic alu_code_valid(input logic [2:0] code);
        return (code == 3'd1) || (code == 3'd2) || (code == 3'd3);
    endfunction

    // ALU codes 1..3 map one-to-one onto EXC_ADD..EXC_SUB.
    function automatic status_t alu_status(input logic [2:0] code);
        return {29'd0, code};
    endfunction

endpackage

// File: rtl/exc_fifo2.sv
// ---------------------------------------------------------------------------
// exc_fifo2
// Two-entry, 32-bit pending-status buffer. Up to two entries may be pushed
// per cycle (i_din0 is the older one); a pop and pushes may happen together.
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset (clears count and entries)
//   i_push   in   number of entries to append this cycle (0..2)
//   i_din0   in   first (older) entry to append
//   i_din1   in   second entry to append
//   i_pop    in   remove the head entry (ignored when empty)
//   i_flush  in   discard all entries and same-cycle pushes
//   o_count  out  occupancy (OCC_EMPTY / OCC_ONE / OCC_FULL)
//   o_head   out  oldest entry
// ---------------------------------------------------------------------------
module exc_fifo2
    import exc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] i_push,
    input  status_t    i_din0,
    input  status_t    i_din1,
    input  logic       i_pop,
    input  logic       i_flush,
    output logic [1:0] o_count,
    output status_t    o_head
);

    logic [1:0] r_occ;
    status_t    r_ent0;
    status_t    r_ent1;

    logic [1:0] w_base;
    logic [2:0] w_sum;
    logic [1:0] w_occ_n;
    status_t    w_q0;
    status_t    w_q1;
    status_t    w_n0;
    status_t    w_n1;

    always_comb begin
        // Apply the pop first, then append pushes behind what remains.
        w_q0   = r_ent0;
        w_q1   = r_ent1;
        w_base = r_occ;
        if (i_pop && (r_occ != OCC_EMPTY)) begin
            w_q0   = r_ent1;
            w_q1   = '0;
            w_base = r_occ - 2'd1;
        end

        w_n0 = w_q0;
        w_n1 = w_q1;
        if (w_base == OCC_EMPTY) begin
            if (i_push != 2'd0) w_n0 = i_din0;
            if (i_push == 2'd2) w_n1 = i_din1;
        end else if (w_base == OCC_ONE) begin
            if (i_push != 2'd0) w_n1 = i_din0;
        end

        // The controller never pushes beyond capacity; clamp defensively.
        w_sum   = {1'b0, w_base} + {1'b0, i_push};
        w_occ_n = (w_sum > {1'b0, OCC_FULL}) ? OCC_FULL : w_sum[1:0];

        if (i_flush) begin
            w_n0    = '0;
            w_n1    = '0;
            w_occ_n = OCC_EMPTY;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_occ  <= OCC_EMPTY;
            r_ent0 <= '0;
            r_ent1 <= '0;
        end else begin
            r_occ  <= w_occ_n;
            r_ent0 <= w_n0;
            r_ent1 <= w_n1;
        end
    end

    assign o_count = r_occ;
    assign o_head  = r_ent0;

endmodule

// File: rtl/exc_wb_ctrl.sv
// ---------------------------------------------------------------------------
// exc_wb_ctrl
// Collects exception/status events from the ALU, the mult/div unit and setx,
// buffers them in a 2-entry FIFO and writes them to the rstatus register
// through the shared regfile write port whenever normal writeback is idle.
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   alu_exc    in   ALU overflow for the writeback-stage instruction
//   alu_code   in   1=add, 2=addi, 3=sub (others invalid)
//   setx_v     in   setx retiring this cycle
//   setx_val   in   setx target value
//   md_exc     in   mult/div finished with exception
//   md_is_div  in   1=div, 0=mul
//   wb_busy    in   normal writeback owns the write port
//   flush      in   discard pending entries and same-cycle events
//   rs_we      out  rstatus write enable
//   rs_waddr   out  rstatus register index (constant RS_ADDR)
//   rs_wdata   out  rstatus write data (0 when not writing)
//   ex_stall   out  a presented event could not be accepted this cycle
//   rstatus_q  out  last value written to rstatus
//   bad_code   out  alu_exc with invalid code, or alu_exc together with setx_v
// ---------------------------------------------------------------------------
module exc_wb_ctrl
    import exc_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,   // only 2 is supported
    parameter int RS_ADDR = RS_ADDR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_exc,
    input  logic [2:0]  alu_code,
    input  logic        setx_v,
    input  logic [31:0] setx_val,
    input  logic        md_exc,
    input  logic        md_is_div,
    input  logic        wb_busy,
    input  logic        flush,
    output logic        rs_we,
    output logic [4:0]  rs_waddr,
    output logic [31:0] rs_wdata,
    output logic        ex_stall,
    output logic [31:0] rstatus_q,
    output logic        bad_code
);

    logic [1:0] w_count;
    status_t    w_head;
    logic       w_deq;
    logic [2:0] w_cap;
    logic       w_alu_ok;
    logic       w_sec_v;
    status_t    w_sec_val;
    status_t    w_md_val;
    logic [2:0] w_n_ev;
    logic [1:0] w_push;
    status_t    w_din0;
    status_t    w_din1;
    status_t    r_rstatus;

    exc_fifo2 u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_din0  (w_din0),
        .i_din1  (w_din1),
        .i_pop   (w_deq),
        .i_flush (flush),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign w_deq    = (w_count != OCC_EMPTY) && !wb_busy;
    assign rs_we    = w_deq;
    assign rs_wdata = w_deq ? w_head : '0;
    assign rs_waddr = 5'(RS_ADDR);

    // A same-cycle dequeue frees a slot for an incoming event.
    assign w_cap = 3'(DEPTH) - {1'b0, w_count} + {2'b0, w_deq};

    // setx and ALU share the younger slot; setx wins if both are raised.
    assign w_alu_ok  = alu_exc && alu_code_valid(alu_code);
    assign w_sec_v   = setx_v || w_alu_ok;
    assign w_sec_val = setx_v ? setx_val : alu_status(alu_code);
    assign w_md_val  = md_is_div ? EXC_DIV : EXC_MUL;
    assign w_n_ev    = {2'b0, md_exc} + {2'b0, w_sec_v};

    // The mult/div event belongs to the older instruction, so it takes the
    // first slot; capacity truncation therefore drops the younger event.
    assign w_din0 = md_exc ? w_md_val : w_sec_val;
    assign w_din1 = w_sec_val;

    always_comb begin
        w_push   = 2'd0;
        ex_stall = 1'b0;
        if (!flush) begin
            if (w_n_ev > w_cap) begin
                ex_stall = 1'b1;
                w_push   = w_cap[1:0];
            end else begin
                w_push   = w_n_ev[1:0];
            end
        end
    end

    // Gated with reset so the flag reads 0 while the block is held in reset.
    assign bad_code = reset && alu_exc && (setx_v || !alu_code_valid(alu_code));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rstatus <= '0;
        end else if (rs_we) begin
            r_rstatus <= rs_wdata;
        end
    end

    assign rstatus_q = r_rstatus;

endmodule

// File: tb/tb_exc_wb_ctrl.sv
module tb_exc_wb_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_exc;
    logic [2:0]  alu_code;
    logic        setx_v;
    logic [31:0] setx_val;
    logic        md_exc;
    logic        md_is_div;
    logic        wb_busy;
    logic        flush;
    logic        rs_we;
    logic [4:0]  rs_waddr;
    logic [31:0] rs_wdata;
    logic        ex_stall;
    logic [31:0] rstatus_q;
    logic        bad_code;

    exc_wb_ctrl #(.DEPTH(2), .RS_ADDR(30)) dut (
        .clock     (clock),
        .reset     (reset),
        .alu_exc   (alu_exc),
        .alu_code  (alu_code),
        .setx_v    (setx_v),
        .setx_val  (setx_val),
        .md_exc    (md_exc),
        .md_is_div (md_is_div),
        .wb_busy   (wb_busy),
        .flush     (flush),
        .rs_we     (rs_we),
        .rs_waddr  (rs_waddr),
        .rs_wdata  (rs_wdata),
        .ex_stall  (ex_stall),
        .rstatus_q (rstatus_q),
        .bad_code  (bad_code)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        md;
        logic        div;
        logic        alu;
        logic [2:0]  code;
        logic        sx;
        logic [31:0] sxv;
        logic        busy;
        logic        fl;
        logic        e_stall;
        logic        e_bad;
        logic        e_we;
        int          npush;
        logic [31:0] pv0;
        logic [31:0] pv1;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    logic [31:0] r_last;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic md, input logic div, input logic alu, input logic [2:0] code,
                       input logic sx, input logic [31:0] sxv, input logic busy, input logic fl,
                       input logic es, input logic eb, input logic ew,
                       input int np, input logic [31:0] p0, input logic [31:0] p1);
        vec_t v;
        v.md = md; v.div = div; v.alu = alu; v.code = code; v.sx = sx; v.sxv = sxv;
        v.busy = busy; v.fl = fl; v.e_stall = es; v.e_bad = eb; v.e_we = ew;
        v.npush = np; v.pv0 = p0; v.pv1 = p1;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic busy, input logic ew);
        add(0, 0, 0, 3'd0, 0, 32'h0, busy, 0, 0, 0, ew, 0, 32'h0, 32'h0);
    endtask

    task automatic drive_idle();
        alu_exc = 0; alu_code = 0; setx_v = 0; setx_val = 0;
        md_exc = 0; md_is_div = 0; wb_busy = 0; flush = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clock);
        md_exc = v.md; md_is_div = v.div; alu_exc = v.alu; alu_code = v.code;
        setx_v = v.sx; setx_val = v.sxv; wb_busy = v.busy; flush = v.fl;
        if (v.npush >= 1) sb.push_back(v.pv0);
        if (v.npush >= 2) sb.push_back(v.pv1);
        #2;
        chk($sformatf("v%0d_stall", idx), {31'd0, ex_stall}, {31'd0, v.e_stall});
        chk($sformatf("v%0d_bad", idx), {31'd0, bad_code}, {31'd0, v.e_bad});
        chk($sformatf("v%0d_we", idx), {31'd0, rs_we}, {31'd0, v.e_we});
        if (v.e_we) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL v%0d_sb_empty got %h want none", idx, rs_wdata);
            end else begin
                r_last = sb.pop_front();
                chk($sformatf("v%0d_wdata", idx), rs_wdata, r_last);
            end
        end else begin
            chk($sformatf("v%0d_wdata_idle", idx), rs_wdata, 32'h0);
        end
        @(posedge clock);
        if (v.fl) sb.delete();
        #1;
        chk($sformatf("v%0d_rstatus", idx), rstatus_q, r_last);
    endtask

    task automatic run_all();
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
        vecs.delete();
    endtask

    initial begin
        r_last = 32'h0;
        drive_idle();
        reset = 1'b0;
        #3;
        chk("rst_we", {31'd0, rs_we}, 32'h0);
        chk("rst_waddr", {27'd0, rs_waddr}, 32'd30);
        chk("rst_wdata", rs_wdata, 32'h0);
        chk("rst_rstatus", rstatus_q, 32'h0);
        chk("rst_stall", {31'd0, ex_stall}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Single ALU sub overflow drains next cycle
        add(0, 0, 1, 3'd3, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'd3, 32'h0);
        idle(0, 1);
        idle(0, 0);
        // md div + setx into empty buffer, held by wb_busy for 3 cycles
        add(1, 1, 0, 3'd0, 1, 32'h0000ABCD, 1, 0, 0, 0, 0, 2, 32'd5, 32'h0000ABCD);
        idle(1, 0);
        idle(1, 0);
        idle(0, 1);
        idle(0, 1);
        idle(0, 0);
        // Full buffer: stall, then dequeue-and-accept in the same cycle
        add(1, 0, 1, 3'd2, 0, 32'h0, 1, 0, 0, 0, 0, 2, 32'd4, 32'd2);
        add(0, 0, 1, 3'd1, 0, 32'h0, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        add(0, 0, 1, 3'd1, 0, 32'h0, 0, 0, 0, 0, 1, 1, 32'd1, 32'h0);
        idle(0, 1);
        idle(0, 1);
        idle(0, 0);
        // Invalid codes and ALU/setx collision
        add(0, 0, 1, 3'd6, 0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
        idle(0, 0);
        add(0, 0, 1, 3'd1, 1, 32'h12345678, 0, 0, 0, 1, 0, 1, 32'h12345678, 32'h0);
        idle(0, 1);
        add(0, 0, 1, 3'd0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
        add(1, 0, 1, 3'd7, 0, 32'h0, 0, 0, 0, 1, 0, 1, 32'd4, 32'h0);
        idle(0, 1);
        // One free slot with two events: md (older) wins, ALU stalls
        add(1, 1, 1, 3'd3, 0, 32'h0, 1, 0, 0, 0, 0, 2, 32'd5, 32'd3);
        add(1, 0, 1, 3'd1, 0, 32'h0, 0, 0, 1, 0, 1, 1, 32'd4, 32'h0);
        add(0, 0, 1, 3'd1, 0, 32'h0, 0, 0, 0, 0, 1, 1, 32'd1, 32'h0);
        idle(0, 1);
        idle(0, 1);
        idle(0, 0);
        // Flush with one pending entry and a same-cycle md event
        add(1, 0, 0, 3'd0, 0, 32'h0, 1, 0, 0, 0, 0, 1, 32'd4, 32'h0);
        add(1, 1, 0, 3'd0, 0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(0, 0);
        idle(0, 0);
        // Flush while dequeuing: the head still writes
        add(0, 0, 1, 3'd2, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'd2, 32'h0);
        add(0, 0, 1, 3'd3, 0, 32'h0, 0, 1, 0, 0, 1, 0, 32'h0, 32'h0);
        idle(0, 0);
        run_all();

        // Asynchronous reset while FULL with a write pending
        @(negedge clock);
        md_exc = 1; md_is_div = 1; setx_v = 1; setx_val = 32'h77; wb_busy = 1;
        @(negedge clock);
        drive_idle();
        #2;
        chk("full_we", {31'd0, rs_we}, 32'd1);
        chk("full_wdata", rs_wdata, 32'd5);
        #1;
        reset = 1'b0;
        alu_exc = 1; alu_code = 3'd6;
        #1;
        chk("arst_we", {31'd0, rs_we}, 32'h0);
        chk("arst_wdata", rs_wdata, 32'h0);
        chk("arst_rstatus", rstatus_q, 32'h0);
        chk("arst_bad", {31'd0, bad_code}, 32'h0);
        chk("arst_waddr", {27'd0, rs_waddr}, 32'd30);
        sb.delete();
        r_last = 32'h0;
        @(negedge clock);
        reset = 1'b1;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #2;
            chk($sformatf("post_rst_we%0d", i), {31'd0, rs_we}, 32'h0);
        end

        // Normal operation resumes after reset
        add(0, 0, 1, 3'd2, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'd2, 32'h0);
        idle(0, 1);
        idle(0, 0);
        run_all();

        chk("sb_drained", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
